// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS ID/EX stage.
//   ALU opcode constants, A-operand select encodings, register-zero constant,
//   the registered ID/EX record type and its bubble value.
package mips_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SRL  = 4'd4;
   localparam logic [3:0] ALU_SRA  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_SLTU = 4'd8;
   localparam logic [3:0] ALU_NOR  = 4'd9;
   localparam logic [3:0] ALU_XOR  = 4'd10;

   typedef enum logic [1:0] {
      A_SEL_RS       = 2'd0,
      A_SEL_SHAMT    = 2'd1,
      A_SEL_RS_SHAMT = 2'd2,
      A_SEL_RSVD     = 2'd3
   } a_sel_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic        valid;
      logic        reg_we;
      logic        is_load;
      logic [3:0]  alu_op;
      a_sel_t      a_sel;
      logic        b_sel;
      logic [4:0]  dst_idx;
      logic [4:0]  rs_idx;
      logic [4:0]  rt_idx;
      logic [4:0]  shamt;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
   } ex_reg_t;

   localparam logic [3:0] BUBBLE_OP = ALU_ADD;
   localparam ex_reg_t EX_BUBBLE = '{alu_op: BUBBLE_OP, a_sel: A_SEL_RS, default: '0};

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the newest value of one source register from MEM, WB or the register copy.
//   i_idx/i_val          : source register number and its registered value
//   i_mem_we/idx/data    : EX/MEM write-back candidate (highest priority)
//   i_wb_we/idx/data     : MEM/WB write-back candidate
//   o_val                : forwarded value; register 0 never forwards
module fwd_mux
   import mips_pkg::*;
(
   input  logic [4:0]  i_idx,
   input  logic [31:0] i_val,
   input  logic        i_mem_we,
   input  logic [4:0]  i_mem_idx,
   input  logic [31:0] i_mem_data,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_idx,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_val
);

   logic w_mem_hit, w_wb_hit;

   assign w_mem_hit = i_mem_we && (i_mem_idx != REG_ZERO) && (i_mem_idx == i_idx);
   assign w_wb_hit  = i_wb_we  && (i_wb_idx  != REG_ZERO) && (i_wb_idx  == i_idx);
   assign o_val     = w_mem_hit ? i_mem_data : w_wb_hit ? i_wb_data : i_val;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand selection, forwarding and stall generation.
//   Inputs : clk, rst_n (async active-low), id_* decoded instruction fields,
//            ex_hold (freeze), flush (bubble), mem_*/wb_* forwarding sources.
//   Outputs: alu_a/alu_b/alu_op to the ALU, ex_valid/ex_reg_we/ex_is_load/ex_dst_idx
//            registered control, ex_store_data (forwarded rt), stall_req to ID/IF.
//   Macro  : ID_EX_FWD_EN enables MEM/WB forwarding and WB capture bypass; without it
//            operands come straight from the registers and every RAW hazard against
//            EX or MEM stalls (register file must be write-first).
module id_ex_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs_idx,
   input  logic [4:0]  id_rt_idx,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [31:0] id_rs_val,
   input  logic [31:0] id_rt_val,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic [3:0]  id_alu_op,
   input  logic [1:0]  id_a_sel,
   input  logic        id_b_sel,
   input  logic [4:0]  id_dst_idx,
   input  logic        id_reg_we,
   input  logic        id_is_load,
   input  logic        ex_hold,
   input  logic        flush,
   input  logic        mem_reg_we,
   input  logic [4:0]  mem_dst_idx,
   input  logic [31:0] mem_result,
   input  logic        wb_reg_we,
   input  logic [4:0]  wb_dst_idx,
   input  logic [31:0] wb_result,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic        ex_valid,
   output logic        ex_reg_we,
   output logic        ex_is_load,
   output logic [4:0]  ex_dst_idx,
   output logic [31:0] ex_store_data,
   output logic        stall_req
);

   ex_reg_t     r_ex, w_load, w_next;
   logic [31:0] w_rs_fwd, w_rt_fwd, w_cap_rs, w_cap_rt;
   logic        w_stall;

`ifdef ID_EX_FWD_EN
   fwd_mux u_fwd_rs (
      .i_idx(r_ex.rs_idx), .i_val(r_ex.rs_val),
      .i_mem_we(mem_reg_we), .i_mem_idx(mem_dst_idx), .i_mem_data(mem_result),
      .i_wb_we(wb_reg_we), .i_wb_idx(wb_dst_idx), .i_wb_data(wb_result),
      .o_val(w_rs_fwd)
   );
   fwd_mux u_fwd_rt (
      .i_idx(r_ex.rt_idx), .i_val(r_ex.rt_val),
      .i_mem_we(mem_reg_we), .i_mem_idx(mem_dst_idx), .i_mem_data(mem_result),
      .i_wb_we(wb_reg_we), .i_wb_idx(wb_dst_idx), .i_wb_data(wb_result),
      .o_val(w_rt_fwd)
   );
   // WB writes the register file in the same cycle ID reads it; take the WB value directly.
   assign w_cap_rs = (wb_reg_we && wb_dst_idx != REG_ZERO && wb_dst_idx == id_rs_idx) ? wb_result : id_rs_val;
   assign w_cap_rt = (wb_reg_we && wb_dst_idx != REG_ZERO && wb_dst_idx == id_rt_idx) ? wb_result : id_rt_val;
   // Only a load in EX cannot be forwarded in time.
   assign w_stall = r_ex.valid && r_ex.is_load && (r_ex.dst_idx != REG_ZERO) && id_valid &&
                    ((id_uses_rs && id_rs_idx == r_ex.dst_idx) || (id_uses_rt && id_rt_idx == r_ex.dst_idx));
`else
   logic w_rs_haz, w_rt_haz, w_unused;
   assign w_rs_fwd = r_ex.rs_val;
   assign w_rt_fwd = r_ex.rt_val;
   assign w_cap_rs = id_rs_val;
   assign w_cap_rt = id_rt_val;
   // Without forwarding, any pending write in EX or MEM to a used source must drain first.
   assign w_rs_haz = id_uses_rs && (id_rs_idx != REG_ZERO) &&
                     ((r_ex.valid && r_ex.reg_we && r_ex.dst_idx == id_rs_idx) || (mem_reg_we && mem_dst_idx == id_rs_idx));
   assign w_rt_haz = id_uses_rt && (id_rt_idx != REG_ZERO) &&
                     ((r_ex.valid && r_ex.reg_we && r_ex.dst_idx == id_rt_idx) || (mem_reg_we && mem_dst_idx == id_rt_idx));
   assign w_stall  = id_valid && (w_rs_haz || w_rt_haz);
   assign w_unused = &{1'b0, mem_result, wb_reg_we, wb_dst_idx, wb_result, r_ex.rs_idx, r_ex.rt_idx};
`endif

   always_comb begin
      w_load = '{valid: id_valid, reg_we: id_reg_we, is_load: id_is_load, alu_op: id_alu_op,
                 a_sel: a_sel_t'(id_a_sel), b_sel: id_b_sel, dst_idx: id_dst_idx,
                 rs_idx: id_rs_idx, rt_idx: id_rt_idx, shamt: id_shamt,
                 rs_val: w_cap_rs, rt_val: w_cap_rt, imm: id_imm};
      w_next = ex_hold ? r_ex : (flush || w_stall) ? EX_BUBBLE : w_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ex <= EX_BUBBLE;
      else        r_ex <= w_next;
   end

   // The ALU shifts by the whole A operand, so shift amounts are masked to 5 bits here.
   assign alu_a = (r_ex.a_sel == A_SEL_SHAMT)    ? {27'b0, r_ex.shamt} :
                  (r_ex.a_sel == A_SEL_RS_SHAMT) ? {27'b0, w_rs_fwd[4:0]} : w_rs_fwd;
   assign alu_b         = r_ex.b_sel ? r_ex.imm : w_rt_fwd;
   assign alu_op        = r_ex.alu_op;
   assign ex_valid      = r_ex.valid;
   assign ex_reg_we     = r_ex.reg_we;
   assign ex_is_load    = r_ex.is_load;
   assign ex_dst_idx    = r_ex.dst_idx;
   assign ex_store_data = w_rt_fwd;
   // rst_n gate keeps the stall quiet while MEM inputs are still live during reset.
   assign stall_req     = w_stall && !ex_hold && rst_n;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage (directed scenarios plus a randomized
//   run against a behavioural model); follows ID_EX_FWD_EN the same way as the design.
module tb_id_ex_stage;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid, id_uses_rs, id_uses_rt, id_b_sel, id_reg_we, id_is_load;
   logic [4:0]  id_rs_idx, id_rt_idx, id_shamt, id_dst_idx;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic [3:0]  id_alu_op;
   logic [1:0]  id_a_sel;
   logic        ex_hold, flush, mem_reg_we, wb_reg_we;
   logic [4:0]  mem_dst_idx, wb_dst_idx;
   logic [31:0] mem_result, wb_result;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_op;
   logic        ex_valid, ex_reg_we, ex_is_load, stall_req;
   logic [4:0]  ex_dst_idx;

   int n_cmp = 0, n_err = 0;

   typedef struct {
      logic        v, we, ld, bsel;
      logic [3:0]  op;
      logic [1:0]  asel;
      logic [4:0]  dst, rs, rt, sh;
      logic [31:0] rsv, rtv, imm;
   } ins_t;
   ins_t m;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_a_sel(id_a_sel),
      .id_b_sel(id_b_sel), .id_dst_idx(id_dst_idx), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
      .ex_hold(ex_hold), .flush(flush), .mem_reg_we(mem_reg_we), .mem_dst_idx(mem_dst_idx),
      .mem_result(mem_result), .wb_reg_we(wb_reg_we), .wb_dst_idx(wb_dst_idx), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid), .ex_reg_we(ex_reg_we),
      .ex_is_load(ex_is_load), .ex_dst_idx(ex_dst_idx), .ex_store_data(ex_store_data),
      .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in;
      {id_valid, id_uses_rs, id_uses_rt, id_b_sel, id_reg_we, id_is_load} = '0;
      {id_rs_idx, id_rt_idx, id_shamt, id_dst_idx, id_alu_op, id_a_sel} = '0;
      {id_rs_val, id_rt_val, id_imm} = '0;
      {ex_hold, flush, mem_reg_we, wb_reg_we, mem_dst_idx, wb_dst_idx, mem_result, wb_result} = '0;
   endtask

   task automatic set_id(input logic [4:0] rs, rt, input logic [31:0] rsv, rtv, input logic [3:0] op,
                         input logic [1:0] asel, input logic bsel, input logic [4:0] sh, dst,
                         input logic ld);
      id_valid = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      id_rs_idx = rs; id_rt_idx = rt; id_rs_val = rsv; id_rt_val = rtv; id_imm = 32'h0000_1234;
      id_alu_op = op; id_a_sel = asel; id_b_sel = bsel; id_shamt = sh; id_dst_idx = dst;
      id_reg_we = 1'b1; id_is_load = ld;
   endtask

   // ---------------- behavioural reference ----------------
   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
`ifdef ID_EX_FWD_EN
      if (mem_reg_we && mem_dst_idx != 0 && mem_dst_idx == idx) return mem_result;
      if (wb_reg_we && wb_dst_idx != 0 && wb_dst_idx == idx) return wb_result;
`endif
      return v;
   endfunction

   function automatic logic [31:0] cap(input logic [4:0] idx, input logic [31:0] v);
`ifdef ID_EX_FWD_EN
      if (wb_reg_we && wb_dst_idx != 0 && wb_dst_idx == idx) return wb_result;
`endif
      return v;
   endfunction

   function automatic logic dep(input logic used, input logic [4:0] idx);
      if (!used || idx == 0) return 1'b0;
`ifdef ID_EX_FWD_EN
      return m.v && m.ld && m.dst == idx;
`else
      return (m.v && m.we && m.dst == idx) || (mem_reg_we && mem_dst_idx == idx);
`endif
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset;
      clear_in;
      #1;
      n_cmp++;
      if ({alu_a, alu_b, alu_op, ex_valid, ex_reg_we, ex_is_load, ex_dst_idx, ex_store_data, stall_req} !== '0) begin
         n_err++; $display("FAIL reset_initial: got a=%h b=%h valid=%b stall=%b, need all 0", alu_a, alu_b, ex_valid, stall_req);
      end
      rst_n = 1'b1;
      set_id(5'd1, 5'd2, 32'h11, 32'h22, 4'd3, 2'd0, 1'b0, 5'd0, 5'd7, 1'b1);
      step;
      n_cmp++;
      if ({ex_valid, ex_is_load, ex_dst_idx, alu_op, alu_a} !== {1'b1, 1'b1, 5'd7, 4'd3, 32'h11}) begin
         n_err++; $display("FAIL reset_load: got valid=%b ld=%b dst=%0d op=%0d a=%h, need 1 1 7 3 11", ex_valid, ex_is_load, ex_dst_idx, alu_op, alu_a);
      end
      set_id(5'd7, 5'd7, 32'h5, 32'h6, 4'd1, 2'd0, 1'b0, 5'd0, 5'd8, 1'b0);
      mem_reg_we = 1'b1; mem_dst_idx = 5'd7; mem_result = 32'hFFFF_0000;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({alu_a, alu_b, alu_op, ex_valid, ex_reg_we, ex_is_load, ex_dst_idx, ex_store_data, stall_req} !== '0) begin
         n_err++; $display("FAIL reset_async: got a=%h b=%h valid=%b stall=%b, need all 0", alu_a, alu_b, ex_valid, stall_req);
      end
      rst_n = 1'b1;
      clear_in;
   endtask

   task automatic test_forwarding;
      logic [31:0] e;
      clear_in;
      set_id(5'd1, 5'd2, 32'h5, 32'h7, 4'd0, 2'd0, 1'b0, 5'd0, 5'd3, 1'b0);
      step;
      clear_in;
      mem_reg_we = 1'b1; mem_dst_idx = 5'd1; mem_result = 32'h10;
      #1;
`ifdef ID_EX_FWD_EN
      e = 32'h10;
`else
      e = 32'h5;
`endif
      n_cmp++;
      if (alu_a !== e) begin n_err++; $display("FAIL fwd_mem_rs: got %h, need %h", alu_a, e); end
      set_id(5'd4, 5'd0, 32'h44, 32'h55, 4'd0, 2'd0, 1'b0, 5'd0, 5'd3, 1'b0);
      mem_reg_we = 1'b0;
      step;
      clear_in;
      mem_reg_we = 1'b1; mem_dst_idx = 5'd4; mem_result = 32'hAA;
      wb_reg_we = 1'b1; wb_dst_idx = 5'd4; wb_result = 32'hBB;
      #1;
`ifdef ID_EX_FWD_EN
      e = 32'hAA;
`else
      e = 32'h44;
`endif
      n_cmp++;
      if (alu_a !== e) begin n_err++; $display("FAIL fwd_mem_over_wb: got %h, need %h", alu_a, e); end
      mem_dst_idx = 5'd0; mem_result = 32'h99; wb_dst_idx = 5'd0; wb_result = 32'h99;
      #1;
      n_cmp++;
      if ({alu_a, alu_b} !== {32'h44, 32'h55}) begin n_err++; $display("FAIL fwd_reg0: got a=%h b=%h, need 44 55", alu_a, alu_b); end
      clear_in;
      set_id(5'd9, 5'd0, 32'h1, 32'h2, 4'd0, 2'd0, 1'b0, 5'd0, 5'd3, 1'b0);
      wb_reg_we = 1'b1; wb_dst_idx = 5'd9; wb_result = 32'h77;
      step;
      clear_in;
      #1;
`ifdef ID_EX_FWD_EN
      e = 32'h77;
`else
      e = 32'h1;
`endif
      n_cmp++;
      if (alu_a !== e) begin n_err++; $display("FAIL capture_bypass: got %h, need %h", alu_a, e); end
   endtask

   task automatic test_load_use;
      clear_in;
      set_id(5'd1, 5'd2, 32'h0, 32'h0, 4'd0, 2'd0, 1'b1, 5'd0, 5'd5, 1'b1);
      step;
      set_id(5'd5, 5'd7, 32'hDEAD, 32'h3, 4'd1, 2'd0, 1'b0, 5'd0, 5'd6, 1'b0);
      #1;
      n_cmp++;
      if (stall_req !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %b, need 1", stall_req); end
      step;
      mem_reg_we = 1'b1; mem_dst_idx = 5'd5; mem_result = 32'h42;
      #1;
      n_cmp++;
      if (ex_valid !== 1'b0) begin n_err++; $display("FAIL load_use_bubble: got valid=%b, need 0", ex_valid); end
`ifdef ID_EX_FWD_EN
      n_cmp++;
      if (stall_req !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %b, need 0", stall_req); end
`else
      n_cmp++;
      if (stall_req !== 1'b1) begin n_err++; $display("FAIL load_use_mem_stall: got %b, need 1", stall_req); end
      step;
      mem_reg_we = 1'b0; id_rs_val = 32'h42;
      #1;
      n_cmp++;
      if (stall_req !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %b, need 0", stall_req); end
`endif
      step;
      id_valid = 1'b0;
      mem_reg_we = 1'b0; wb_reg_we = 1'b1; wb_dst_idx = 5'd5; wb_result = 32'h42;
      #1;
      n_cmp++;
      if ({ex_valid, alu_op, alu_a, alu_b} !== {1'b1, 4'd1, 32'h42, 32'h3}) begin
         n_err++; $display("FAIL load_use_resolve: got valid=%b op=%0d a=%h b=%h, need 1 1 42 3", ex_valid, alu_op, alu_a, alu_b);
      end
      clear_in;
   endtask

   task automatic test_shift;
      clear_in;
      set_id(5'd9, 5'd10, 32'h0000_0123, 32'hCAFE, 4'd6, 2'd2, 1'b0, 5'd0, 5'd3, 1'b0);
      step;
      n_cmp++;
      if ({alu_a, alu_b} !== {32'h3, 32'hCAFE}) begin n_err++; $display("FAIL sllv_mask: got a=%h b=%h, need 3 cafe", alu_a, alu_b); end
      set_id(5'd9, 5'd10, 32'hFFFF_FFFF, 32'hBEEF, 4'd6, 2'd1, 1'b1, 5'd31, 5'd3, 1'b0);
      step;
      n_cmp++;
      if ({alu_a, alu_b, ex_store_data} !== {32'd31, 32'h1234, 32'hBEEF}) begin
         n_err++; $display("FAIL sll_shamt_imm: got a=%h b=%h sd=%h, need 1f 1234 beef", alu_a, alu_b, ex_store_data);
      end
      clear_in;
   endtask

   task automatic test_hold_flush;
      clear_in;
      set_id(5'd1, 5'd2, 32'h0, 32'h0, 4'd0, 2'd0, 1'b1, 5'd0, 5'd5, 1'b1);
      step;
      set_id(5'd5, 5'd5, 32'h0, 32'h0, 4'd0, 2'd0, 1'b0, 5'd0, 5'd6, 1'b0);
      ex_hold = 1'b1; flush = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++;
         if (stall_req !== 1'b0) begin n_err++; $display("FAIL hold_stall cyc %0d: got %b, need 0", k, stall_req); end
         step;
         n_cmp++;
         if ({ex_valid, ex_is_load, ex_dst_idx} !== {1'b1, 1'b1, 5'd5}) begin
            n_err++; $display("FAIL hold_retain cyc %0d: got valid=%b ld=%b dst=%0d, need 1 1 5", k, ex_valid, ex_is_load, ex_dst_idx);
         end
      end
      ex_hold = 1'b0;
      step;
      n_cmp++;
      if ({ex_valid, ex_reg_we, ex_dst_idx} !== '0) begin
         n_err++; $display("FAIL flush_bubble: got valid=%b we=%b dst=%0d, need 0 0 0", ex_valid, ex_reg_we, ex_dst_idx);
      end
      clear_in;
   endtask

   task automatic test_random;
      logic [31:0] frs, frt, ea, eb;
      logic        s;
      clear_in;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m = '{default: '0};
      for (int i = 0; i < 400; i++) begin
         id_valid = 1'($urandom_range(0, 3) != 0);
         id_rs_idx = 5'($urandom_range(0, 3)); id_rt_idx = 5'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
         id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
         id_shamt = 5'($urandom); id_alu_op = 4'($urandom_range(0, 10));
         id_a_sel = 2'($urandom); id_b_sel = 1'($urandom);
         id_dst_idx = 5'($urandom_range(0, 3)); id_reg_we = 1'($urandom); id_is_load = 1'($urandom);
         ex_hold = 1'($urandom_range(0, 7) == 0); flush = 1'($urandom_range(0, 7) == 0);
         mem_reg_we = 1'($urandom); mem_dst_idx = 5'($urandom_range(0, 3)); mem_result = $urandom;
         wb_reg_we = 1'($urandom); wb_dst_idx = 5'($urandom_range(0, 3)); wb_result = $urandom;
         #1;
         frs = fwd(m.rs, m.rsv);
         frt = fwd(m.rt, m.rtv);
         ea = (m.asel == 2'd1) ? {27'b0, m.sh} : (m.asel == 2'd2) ? (frs & 32'h1F) : frs;
         eb = m.bsel ? m.imm : frt;
         s = id_valid && !ex_hold && (dep(id_uses_rs, id_rs_idx) || dep(id_uses_rt, id_rt_idx));
         n_cmp++;
         if ({alu_a, alu_b, ex_store_data} !== {ea, eb, frt}) begin
            n_err++; $display("FAIL rand_data cyc %0d: got a=%h b=%h sd=%h, need a=%h b=%h sd=%h", i, alu_a, alu_b, ex_store_data, ea, eb, frt);
         end
         n_cmp++;
         if ({alu_op, ex_valid, ex_reg_we, ex_is_load, ex_dst_idx, stall_req} !== {m.op, m.v, m.we, m.ld, m.dst, s}) begin
            n_err++; $display("FAIL rand_ctrl cyc %0d: got op=%0d v=%b we=%b ld=%b dst=%0d st=%b, need %0d %b %b %b %0d %b",
                              i, alu_op, ex_valid, ex_reg_we, ex_is_load, ex_dst_idx, stall_req, m.op, m.v, m.we, m.ld, m.dst, s);
         end
         if (!ex_hold) begin
            if (flush || s) m = '{default: '0};
            else m = '{v: id_valid, we: id_reg_we, ld: id_is_load, bsel: id_b_sel, op: id_alu_op,
                       asel: id_a_sel, dst: id_dst_idx, rs: id_rs_idx, rt: id_rt_idx, sh: id_shamt,
                       rsv: cap(id_rs_idx, id_rs_val), rtv: cap(id_rt_idx, id_rt_val), imm: id_imm};
         end
         step;
      end
      clear_in;
   endtask

   initial begin
      test_reset;
      test_forwarding;
      test_load_use;
      test_shift;
      test_hold_flush;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

- ID/EX pipeline register plus EX-side operand selection for the five-stage MIPS core.
- Sits directly upstream of the ALU and drives its `A`, `B` and `Op` inputs.
- Captures decoded instructions and resolves RAW hazards by MEM/WB forwarding and load-use stall generation.
- Inserts bubbles on stall or flush.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_rs_idx`, `id_rt_idx`  in  5 each  source register numbers
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction actually reads rs / rt
- `id_rs_val`, `id_rt_val`  in  32 each  register-file read data
- `id_imm`  in  32  immediate, already sign/zero-extended by ID
- `id_shamt`  in  5  shift amount field
- `id_alu_op`  in  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, 6 sll, 7 slt, 8 sltu, 9 nor, 10 xor
- `id_a_sel`  in  2  A source: 0 rs, 1 shamt, 2 rs[4:0] (variable shift); 3 reserved, treated as 0
- `id_b_sel`  in  1  B source: 0 rt, 1 imm
- `id_dst_idx`  in  5  destination register number
- `id_reg_we`  in  1  instruction writes a register
- `id_is_load`  in  1  instruction is a load
- `ex_hold`  in  1  downstream stall; freeze this stage
- `flush`  in  1  kill the instruction entering EX
- `mem_reg_we`, `mem_dst_idx`, `mem_result`  in  1/5/32  EX/MEM forwarding source; never a load result
- `wb_reg_we`, `wb_dst_idx`, `wb_result`  in  1/5/32  MEM/WB forwarding source
- `alu_a`, `alu_b`  out  32 each  ALU operands
- `alu_op`  out  4  ALU opcode
- `ex_valid`, `ex_reg_we`, `ex_is_load`  out  1 each  registered control
- `ex_dst_idx`  out  5  registered destination
- `ex_store_data`  out  32  forwarded rt, for stores
- `stall_req`  out  1  ID and IF must hold this cycle

## Operation
- **Register update priority each edge:** `ex_hold` (retain) > `flush` (bubble) > `stall_req` (bubble) > load ID fields.
  - Bubble: `valid`, `we` and `is_load` are 0, `alu_op` is 0, all data fields are 0.
  - Upstream keeps `flush` asserted while `ex_hold` is high.
- **Capture bypass:** when loading, if `wb_reg_we` is set, `wb_dst_idx` is nonzero and it matches `id_rs_idx` (or `id_rt_idx`), the stage captures `wb_result` instead of the register-file value. This covers the write and read happening in the same cycle.
- **EX forwarding per operand, combinational from registered rs/rt:**
  - MEM match (we set, dst ≠ 0, indices equal) takes `mem_result`.
  - Otherwise a WB match takes `wb_result`.
  - Otherwise the registered value is used.
  - MEM has priority over WB.
  - Register 0 never forwards.
- **Operand selection:**
  - `alu_a` = forwarded rs, `{27'b0, shamt}`, or `{27'b0, fwd_rs[4:0]}`, according to `id_a_sel`.
  - `alu_b` = forwarded rt or imm, according to `id_b_sel`.
  - Shift amounts are always masked to 5 bits, because the ALU shifts by the full A.
- **Load-use stall:** `stall_req` = `ex_valid & ex_is_load & (ex_dst_idx≠0) & id_valid & ((id_uses_rs & id_rs_idx==ex_dst_idx) | (id_uses_rt & id_rt_idx==ex_dst_idx))`.
  - `stall_req` is forced to 0 while `ex_hold` is high.
- `ex_store_data` = forwarded rt, regardless of `id_b_sel`.

## Timing
- One-cycle latency from ID to the registered EX fields.
- `alu_a`, `alu_b`, `ex_store_data` and `stall_req` are combinational in the same cycle from the registers and the forwarding inputs.
- A stall lasts exactly one cycle per load-use pair. The next cycle the load is in MEM and the bubble is in EX, so `stall_req` drops.
- Asserting `rst_n` low at any time immediately clears all registers.
  - Every output resets to 0; `alu_op` resets to 0 (add).
  - No stall is requested.
- Simultaneous `flush` and `stall_req` still produce a single bubble.

## Configuration
- Macro: `ID_EX_FWD_EN`.
- **Defined:** EX forwarding and capture bypass exactly as above.
- **Undefined:**
  - Forwarding muxes and capture bypass are removed; operands come straight from the registers.
  - `stall_req` asserts for any RAW hazard against an EX instruction with `ex_reg_we`, or against the MEM stage (`mem_reg_we`/`mem_dst_idx`), on a used, nonzero source.
  - The register file must then be write-first.

## Structure
- **Shared package `mips_pkg`:**
  - ALU opcode constants (`ALU_ADD`=0 … `ALU_XOR`=10).
  - A-select encodings.
  - Bubble field values.
  - Register-zero constant.
- **Sub-module `fwd_mux`** (index, registered value, MEM/WB we/idx/data in; forwarded value out), instantiated for rs and rt.

## Test plan
- Reset mid-run with `rst_n`=0 → all outputs 0, `ex_valid`=0 without waiting for a clock edge.
- `add $3,$1,$2` directly following `add $1,…`, with `mem_result`=0x10 → `alu_a`=0x10 while in EX; register value 0x5 is ignored.
- MEM and WB both target $4 (0xAA / 0xBB) → forwarded rs = 0xAA; dst $0 with value 0x99 → no forward.
- `lw $5` followed by `sub $6,$5,$7` → `stall_req`=1 for exactly one cycle, EX holds a bubble (`ex_valid`=0), then forwarding resolves.
- `sllv` with rs=0x0000_0123 → `alu_a`=0x3; `sll` with shamt=31 → `alu_a`=31.
- `ex_hold` and `flush` both high for 2 cycles → EX contents unchanged and `stall_req`=0; after release, `flush` inserts a bubble.
